// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Exhaustive-stimulus and response-capture engine for a 4-input combinational
// circuit. When started, it drives vectors 0..15 onto {a,b,c,d}, with a as the
// MSB. It holds each vector for DWELL cycles and samples y on the edge that
// ends each dwell. It then assembles the 16-bit captured truth table and
// compares it against EXPECTED.
//
// Parameters
//   DWELL     cycles each vector is held (legal range 2..255)
//   EXPECTED  expected truth table; bit k is the y value for vector k
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request, sampled only while idle
//   y          in   output of the circuit under test
//   a,b,c,d    out  stimulus; {a,b,c,d} = vector index
//   busy       out  high while a run is in progress
//   done       out  one-cycle pulse at run completion
//   pass       out  captured == EXPECTED; valid from done until the next start
//   captured   out  captured truth table; bit k = sampled y for vector k
//
// Optional feature (macro TTC_MISMATCH_LOG_EN):
//   fail_count out  number of mismatching vectors (0..16)
//   first_fail out  index of the first mismatching vector (0 if none)
// ---------------------------------------------------------------------------
module truth_table_checker #(
    parameter int unsigned DWELL    = 5,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured
`ifdef TTC_MISMATCH_LOG_EN
    ,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail
`endif
);

    // Dwell counter only needs to reach DWELL-1.
    localparam int unsigned   CW   = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    idx;
    logic [CW-1:0] dwell_cnt;
    logic          go;
    logic          dwell_end;
    logic          last_vec;
    logic [15:0]   captured_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        go         = 1'b0;
        dwell_end  = 1'b0;
        last_vec   = 1'b0;
        unique case (state)
            S_IDLE: begin
                go = start;
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                dwell_end = (dwell_cnt == LAST);
                last_vec  = dwell_end && (idx == 4'd15);
                if (last_vec) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Table value including the bit being sampled on this edge.
    always_comb begin
        captured_next      = captured;
        captured_next[idx] = y;
    end

    // ------------------------------------------------------------------
    // Datapath: vector index, dwell counter, capture and verdict
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            dwell_cnt <= '0;
            captured  <= '0;
            pass      <= 1'b0;
        end else if (go) begin
            idx       <= '0;
            dwell_cnt <= '0;
            captured  <= '0;
            pass      <= 1'b0;
        end else if (state == S_RUN) begin
            if (dwell_end) begin
                captured  <= captured_next;
                dwell_cnt <= '0;
                if (last_vec) begin
                    // idx returns to 0 so the stimulus reads 0000 outside RUN.
                    // The verdict uses the final table on this edge, which
                    // makes pass valid in the same cycle as done.
                    idx  <= '0;
                    pass <= (captured_next == EXPECTED);
                end else begin
                    idx <= idx + 4'd1;
                end
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

    // Stimulus comes straight from the idx register, so it cannot glitch.
    assign {a, b, c, d} = idx;
    assign busy         = (state == S_RUN);
    assign done         = (state == S_DONE);

`ifdef TTC_MISMATCH_LOG_EN
    // ------------------------------------------------------------------
    // Per-vector mismatch log
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || go) begin
            fail_count <= '0;
            first_fail <= '0;
        end else if (dwell_end && (y != EXPECTED[idx])) begin
            fail_count <= fail_count + 5'd1;
            if (fail_count == '0) begin
                first_fail <= idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// ---------------------------------------------------------------------------
// tb_truth_table_checker
//
// Drives two checker instances (DWELL=5 / EXPECTED=F888 and DWELL=3 /
// EXPECTED=F889) against a modelled lab circuit. The modelled circuit
// presents the inverted response until the last cycle of each dwell.
// Expected outputs come from cycle arithmetic on the run's start time.
// ---------------------------------------------------------------------------
module tb_truth_table_checker;

    localparam int          D0 = 5;
    localparam int          D1 = 3;
    localparam logic [15:0] E0 = 16'hF888;
    localparam logic [15:0] E1 = 16'hF889;

    logic        clk = 1'b0;
    logic        rst;
    logic        start   [2];
    logic        y_w     [2];
    logic        a_w     [2];
    logic        b_w     [2];
    logic        c_w     [2];
    logic        d_w     [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic        pass_w  [2];
    logic [15:0] cap_w   [2];
`ifdef TTC_MISMATCH_LOG_EN
    logic [4:0]  fc_w    [2];
    logic [3:0]  ff_w    [2];
`endif

    logic [15:0] tt      [2];
    logic        glitch  [2];
    int          run_s   [2];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Modelled circuit: the response is only correct in the last cycle of
    // each dwell, so a capture taken earlier sees the inverted value.
    assign y_w[0] = tt[0][{a_w[0], b_w[0], c_w[0], d_w[0]}]
                    ^ (glitch[0] && (((cyc - run_s[0]) % D0) != D0 - 1));
    assign y_w[1] = tt[1][{a_w[1], b_w[1], c_w[1], d_w[1]}]
                    ^ (glitch[1] && (((cyc - run_s[1]) % D1) != D1 - 1));

    truth_table_checker #(.DWELL(D0), .EXPECTED(E0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .y(y_w[0]),
        .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .captured(cap_w[0])
`ifdef TTC_MISMATCH_LOG_EN
        , .fail_count(fc_w[0]), .first_fail(ff_w[0])
`endif
    );

    truth_table_checker #(.DWELL(D1), .EXPECTED(E1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .y(y_w[1]),
        .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .captured(cap_w[1])
`ifdef TTC_MISMATCH_LOG_EN
        , .fail_count(fc_w[1]), .first_fail(ff_w[1])
`endif
    );

    function automatic logic [3:0] vec_of(input int i);
        return {a_w[i], b_w[i], c_w[i], d_w[i]};
    endfunction

    function automatic logic [15:0] mask_n(input int n);
        logic [16:0] m;
        m = (17'd1 << n) - 17'd1;
        return m[15:0];
    endfunction

    function automatic int popcount(input logic [15:0] v);
        int n = 0;
        for (int k = 0; k < 16; k++) n += int'(v[k]);
        return n;
    endfunction

    function automatic int lowest(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[k]) return k;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        check({tag, " busy"}, busy_w[i], 0);
        check({tag, " done"}, done_w[i], 0);
        check({tag, " vector"}, vec_of(i), 0);
        check({tag, " captured"}, cap_w[i], 0);
        check({tag, " pass"}, pass_w[i], 0);
`ifdef TTC_MISMATCH_LOG_EN
        check({tag, " fail_count"}, fc_w[i], 0);
        check({tag, " first_fail"}, ff_w[i], 0);
`endif
    endtask

    // One full run, checked every cycle from the first RUN cycle (t=0)
    // to the first IDLE cycle after done (t=16*dwell+1).
    task automatic run_check(input int i, input logic [15:0] tbl, input int repulse_t);
        int          dw;
        int          lat;
        int          nd;
        logic [15:0] ex;
        logic [15:0] m;
        dw  = (i == 0) ? D0 : D1;
        ex  = (i == 0) ? E0 : E1;
        lat = 16 * dw;
        tt[i]     = tbl;
        glitch[i] = 1'b1;
        start[i]  = 1'b1;
        run_s[i]  = cyc + 1;
        @(negedge clk);
        for (int t = 0; t <= lat + 1; t++) begin
            start[i] = (t == repulse_t);
            nd = (t < lat) ? t / dw : 16;
            m  = mask_n(nd);
            check("busy", busy_w[i], 32'(t < lat));
            check("done", done_w[i], 32'(t == lat));
            check("vector", vec_of(i), (t < lat) ? t / dw : 0);
            check("captured", cap_w[i], tbl & m);
            check("pass", pass_w[i], 32'((t >= lat) && (tbl == ex)));
`ifdef TTC_MISMATCH_LOG_EN
            check("fail_count", fc_w[i], popcount((tbl ^ ex) & m));
            check("first_fail", ff_w[i], lowest((tbl ^ ex) & m));
`endif
            @(negedge clk);
        end
        start[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lab;
        logic [3:0]  kv;
        int          nd;
        int          n;
        int          last;
        int          s;

        for (int k = 0; k < 16; k++) begin
            kv     = 4'(k);
            lab[k] = (kv[3] & kv[2]) | (kv[1] & kv[0]);
        end
        for (int i = 0; i < 2; i++) begin
            start[i]  = 1'b0;
            tt[i]     = '0;
            glitch[i] = 1'b0;
            run_s[i]  = 0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle(0, "reset dut0");
        check_idle(1, "reset dut1");
        rst = 1'b0;
        @(negedge clk);

        // (a&b)|(c&d): matches dut0 expectation, misses dut1's bit 0
        run_check(0, lab, -1);
        run_check(1, lab, -1);

        // start pulsed again during vector 4 is ignored
        run_check(0, lab, 4 * D0);

        // Reset during vector 7 aborts the run
        tt[0]     = lab;
        glitch[0] = 1'b1;
        start[0]  = 1'b1;
        run_s[0]  = cyc + 1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (7 * D0 + 2) @(negedge clk);
        check("pre-abort vector", vec_of(0), 7);
        rst = 1'b1;
        @(negedge clk);
        check_idle(0, "abort");
        rst = 1'b0;
        nd = 0;
        repeat (20 * D0) begin
            @(negedge clk);
            if (done_w[0]) nd++;
        end
        check("abort done pulses", nd, 0);
        check("abort busy", busy_w[0], 0);
        run_check(0, lab, -1);

        // Random lab circuits on both instances
        for (int r = 0; r < 3; r++) begin
            run_check(0, 16'($urandom), -1);
            run_check(1, 16'($urandom), -1);
        end
        run_check(1, E1, -1);

        // start held high: back-to-back runs
        tt[1]     = lab;
        glitch[1] = 1'b0;
        start[1]  = 1'b1;
        s         = cyc + 1;
        n         = 0;
        last      = 0;
        for (int k = 0; k < 4 * (16 * D1 + 2) + 10 && n < 3; k++) begin
            @(negedge clk);
            if (done_w[1]) begin
                if (n == 0) check("held first latency", cyc - s, 16 * D1);
                else        check("held rearm period", cyc - last, 16 * D1 + 2);
                check("held captured", cap_w[1], lab);
                check("held pass", pass_w[1], 0);
                last = cyc;
                n++;
            end
        end
        check("held done count", n, 3);
        start[1] = 1'b0;
        for (int k = 0; k < 16 * D1 + 10 && (busy_w[1] || done_w[1]); k++) @(negedge clk);
        @(negedge clk);
        check("held drain busy", busy_w[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
